kypd_emulator: RTL and testbench
================================

# kypd_emulator

Keypad emulator that drives the active-low `row[3:0]` lines of the 4x4 PMOD keypad interface in response to the column strobes `col[3:0]` produced by the keypad scanner. It "types" a 4-digit hex code, one key press and release per digit, most significant digit first. It replaces the physical keypad in self-test and remote-entry paths of the digital lock, so the scanner and lock logic are exercised unchanged.

## Interface
- `HOLD_CYCLES`, default 16: clk cycles each key is held down; legal range >= 8.
- `GAP_CYCLES`, default 16: clk cycles of release after each key; legal range >= 8.
- `clk`  input  1  single clock; all state updates on posedge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  request to type `code`; sampled only in IDLE.
- `abort`  input  1  synchronous cancel of a sequence in progress.
- `code`  input  16  four hex digits; `code[15:12]` is typed first.
- `col`  input  4  column strobes from the scanner, active-low.
- `row`  output  4  emulated row lines, active-low.
- `busy`  output  1  high from first PRESS cycle through DONE.
- `done`  output  1  one-cycle pulse when the 4th release completes.
- `key_active`  output  1  high while the current key is held (PRESS).

## Operation
- Key map, as (column, row): 1=(0,0), 4=(0,1), 7=(0,2), 0=(0,3); 2=(1,0), 5=(1,1), 8=(1,2), F=(1,3); 3=(2,0), 6=(2,1), 9=(2,2), E=(2,3); A=(3,0), B=(3,1), C=(3,2), D=(3,3).
- Row drive is combinational from `col` and registered key position:
  - `row[r] = 0` only when `key_active` = 1, `r` equals the key row, and `col[key column]` = 0.
  - Otherwise `row[r] = 1`.
  - If several columns are low at once, the key still appears only on its own column.
  - If all columns are high, `row` = 4'b1111.
- States:
  - IDLE: `row` = 1111. On `start` = 1, latch `code` into a shift register, set digit index to 0, then go to PRESS.
  - PRESS: `key_active` = 1 with the key for the current digit. After HOLD_CYCLES cycles, go to RELEASE.
  - RELEASE: `key_active` = 0. After GAP_CYCLES cycles, if index < 3, increment the index and return to PRESS; else go to DONE.
  - DONE: `done` = 1 for exactly one cycle, then go to IDLE.
- `start` while not in IDLE is ignored. `code` is not re-sampled during a sequence.
- `abort` = 1 in PRESS, RELEASE or DONE:
  - next state is IDLE and the index is cleared;
  - no `done` pulse;
  - `abort` has priority over count expiry in the same cycle.
- `abort` in IDLE has no effect. If `abort` and `start` are both high in IDLE, `start` wins.
- Digit counter width is 2 bits. The hold/gap counter width is `$clog2(max(HOLD_CYCLES,GAP_CYCLES)+1)`. The counter reloads to 0 on every state entry.

## Timing
- Reset (async assert, sync-free deassert): state = IDLE, `row` = 4'b1111, `busy` = 0, `done` = 0, `key_active` = 0, counters = 0, shift register = 0.
- `rst_n` low mid-sequence forces `row` to 1111 immediately, without waiting for a clock edge.
- `start` high at posedge N:
  - PRESS of digit 0 spans cycles N+1 .. N+HOLD_CYCLES, with `busy` = 1 from cycle N+1.
  - Digit k PRESS begins at N+1+k*(HOLD_CYCLES+GAP_CYCLES).
  - `done` is high in cycle N+1+4*(HOLD_CYCLES+GAP_CYCLES).
  - `busy` = 0 the following cycle.
- Minimum HOLD/GAP of 8 guarantees at least two full 4-column scans per press and per release, at the scanner's 1-column-per-clk rate.
- `row` responds to `col` with zero cycles of latency, so it is valid before the scanner's negedge sample.

## Structure
- Shared package `kypd_pkg`:
  - column/row position constants for all 16 keys;
  - the state encoding (IDLE, PRESS, RELEASE, DONE);
  - the MIN_HOLD value of 8.
- Sub-module `kypd_key_map`: combinational, 4-bit key in, 2-bit column and 2-bit row out. It is the inverse of the scanner's key decode and is reusable by the bench.

## Test plan
- Reset: assert `rst_n` = 0 mid-PRESS of code 16'h1234 -> `row` = 1111 immediately; `busy`, `done` and `key_active` = 0.
- Code 16'h1234, HOLD = GAP = 8 -> digit 1 pulls `row[0]` low only while `col` = 1110; `done` at N+65.
- Closed loop with the keypad scanner, code 16'hFEDA -> scanner `number` = 16'hFEDA and `new_cycle` = 1 after the 4th release.
- Code 16'h0A5C -> rows/cols observed: (0,3), (3,0), (1,1), (3,2), in that order.
- `start` pulsed again during digit 2 with `code` = 16'h9999 -> ignored; original code completes and exactly one `done` is seen.
- `abort` in the 3rd PRESS cycle of digit 1 -> `row` = 1111 next cycle, back in IDLE, no `done`; a new `start` then types correctly from digit 0.

Source files
------------

// File: rtl/kypd_pkg.sv
// Shared definitions for the keypad emulator: key positions, FSM encoding,
// and the minimum hold/release length.
`timescale 1ns/1ps
package kypd_pkg;

  // Eight cycles give the scanner two full 4-column sweeps per press/release.
  localparam int MIN_HOLD = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESS   = 2'd1,
    ST_RELEASE = 2'd2,
    ST_DONE    = 2'd3
  } kypd_state_t;

  typedef struct packed {
    logic [1:0] col;
    logic [1:0] row;
  } key_pos_t;

  // (column, row) of every key on the 4x4 pad
  localparam key_pos_t POS_KEY_1 = '{col: 2'd0, row: 2'd0};
  localparam key_pos_t POS_KEY_4 = '{col: 2'd0, row: 2'd1};
  localparam key_pos_t POS_KEY_7 = '{col: 2'd0, row: 2'd2};
  localparam key_pos_t POS_KEY_0 = '{col: 2'd0, row: 2'd3};
  localparam key_pos_t POS_KEY_2 = '{col: 2'd1, row: 2'd0};
  localparam key_pos_t POS_KEY_5 = '{col: 2'd1, row: 2'd1};
  localparam key_pos_t POS_KEY_8 = '{col: 2'd1, row: 2'd2};
  localparam key_pos_t POS_KEY_F = '{col: 2'd1, row: 2'd3};
  localparam key_pos_t POS_KEY_3 = '{col: 2'd2, row: 2'd0};
  localparam key_pos_t POS_KEY_6 = '{col: 2'd2, row: 2'd1};
  localparam key_pos_t POS_KEY_9 = '{col: 2'd2, row: 2'd2};
  localparam key_pos_t POS_KEY_E = '{col: 2'd2, row: 2'd3};
  localparam key_pos_t POS_KEY_A = '{col: 2'd3, row: 2'd0};
  localparam key_pos_t POS_KEY_B = '{col: 2'd3, row: 2'd1};
  localparam key_pos_t POS_KEY_C = '{col: 2'd3, row: 2'd2};
  localparam key_pos_t POS_KEY_D = '{col: 2'd3, row: 2'd3};

endpackage

// File: rtl/kypd_key_map.sv
// Hex key value to (column, row) position on the keypad; the inverse of the
// scanner's key decode.
`timescale 1ns/1ps
module kypd_key_map
  import kypd_pkg::*;
(
  input  logic [3:0] key,
  output logic [1:0] key_col,
  output logic [1:0] key_row
);

  key_pos_t pos;

  // Table lookup of the key position
  always_comb begin
    pos = POS_KEY_0;
    case (key)
      4'h0: pos = POS_KEY_0;
      4'h1: pos = POS_KEY_1;
      4'h2: pos = POS_KEY_2;
      4'h3: pos = POS_KEY_3;
      4'h4: pos = POS_KEY_4;
      4'h5: pos = POS_KEY_5;
      4'h6: pos = POS_KEY_6;
      4'h7: pos = POS_KEY_7;
      4'h8: pos = POS_KEY_8;
      4'h9: pos = POS_KEY_9;
      4'hA: pos = POS_KEY_A;
      4'hB: pos = POS_KEY_B;
      4'hC: pos = POS_KEY_C;
      4'hD: pos = POS_KEY_D;
      4'hE: pos = POS_KEY_E;
      4'hF: pos = POS_KEY_F;
      default: pos = POS_KEY_0;
    endcase
  end

  assign key_col = pos.col;
  assign key_row = pos.row;

endmodule

// File: rtl/kypd_emulator.sv
// Keypad emulator: types a 4-digit hex code onto the active-low row lines in
// response to the scanner's column strobes, one press/release per digit.
//
// state      | meaning
// -----------+-----------------------------------------------
// ST_IDLE    | rows released, waiting for start
// ST_PRESS   | current digit held for HOLD_CYCLES
// ST_RELEASE | all keys released for GAP_CYCLES
// ST_DONE    | one-cycle done pulse, then back to idle
`timescale 1ns/1ps
module kypd_emulator
  import kypd_pkg::*;
#(
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] code,
  input  logic [3:0]  col,
  output logic [3:0]  row,
  output logic        busy,
  output logic        done,
  output logic        key_active
);

  // Out-of-range lengths are clamped so the scanner always sees full sweeps.
  localparam int HOLD_EFF = (HOLD_CYCLES < MIN_HOLD) ? MIN_HOLD : HOLD_CYCLES;
  localparam int GAP_EFF  = (GAP_CYCLES  < MIN_HOLD) ? MIN_HOLD : GAP_CYCLES;
  localparam int CNT_MAX  = (HOLD_EFF > GAP_EFF) ? HOLD_EFF : GAP_EFF;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_EFF - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_EFF - 1);

  kypd_state_t      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       idx, idx_nxt;
  logic [15:0]      code_sr, code_sr_nxt;
  logic [1:0]       key_col, key_row;

  kypd_key_map u_key_map (
    .key     (code_sr[15:12]),
    .key_col (key_col),
    .key_row (key_row)
  );

  // State, cycle counter, digit index and code shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      idx     <= '0;
      code_sr <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      idx     <= idx_nxt;
      code_sr <= code_sr_nxt;
    end
  end

  // Next-state logic and status outputs; abort outranks count expiry
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt + 1'b1;
    idx_nxt     = idx;
    code_sr_nxt = code_sr;
    busy        = 1'b1;
    done        = 1'b0;
    key_active  = 1'b0;

    case (state)
      ST_IDLE: begin
        busy    = 1'b0;
        cnt_nxt = '0;
        if (start) begin
          state_nxt   = ST_PRESS;
          code_sr_nxt = code;
          idx_nxt     = '0;
        end
      end
      ST_PRESS: begin
        key_active = 1'b1;
        if (cnt == HOLD_LAST) begin
          state_nxt = ST_RELEASE;
          cnt_nxt   = '0;
        end
      end
      ST_RELEASE: begin
        if (cnt == GAP_LAST) begin
          cnt_nxt = '0;
          if (idx != 2'd3) begin
            state_nxt   = ST_PRESS;
            idx_nxt     = idx + 2'd1;
            code_sr_nxt = {code_sr[11:0], 4'h0};
          end else begin
            state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        done      = ~abort;
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
        idx_nxt   = '0;
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase

    if (abort && (state != ST_IDLE)) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
      idx_nxt   = '0;
    end
  end

  // Pull the key's row low only while its own column is strobed
  always_comb begin
    row = 4'b1111;
    if (key_active && !col[key_col]) begin
      row[key_row] = 1'b0;
    end
  end

endmodule

// File: tb/tb_kypd_emulator.sv
// Bench for kypd_emulator: direct column drive for timing checks and a
// behavioural keypad scanner feeding a scoreboard for closed-loop checks.
`timescale 1ns/1ps
module tb_kypd_emulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [15:0] code;
  logic [3:0]  col;
  logic [3:0]  row;
  logic        busy;
  logic        done;
  logic        key_active;

  int n_checks = 0;
  int n_fail   = 0;

  // scanner model state
  logic       scan_en = 1'b0;
  logic [3:0] man_col = 4'b1111;
  logic [1:0] scan_idx = 2'd0;
  logic       seen_scan = 1'b0;
  logic       held = 1'b0;
  logic [3:0] seen_pos = 4'h0;
  logic [15:0] number = 16'h0;
  int         rel_cnt = 0;
  logic       new_cycle_seen = 1'b0;

  // scoreboard
  logic [3:0] exp_key_q[$];
  logic [3:0] got_key_q[$];
  logic [3:0] exp_pos_q[$];
  logic [3:0] got_pos_q[$];

  always #5 clk = ~clk;

  assign col = scan_en ? ~(4'b0001 << scan_idx) : man_col;

  kypd_emulator #(.HOLD_CYCLES(8), .GAP_CYCLES(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .code       (code),
    .col        (col),
    .row        (row),
    .busy       (busy),
    .done       (done),
    .key_active (key_active)
  );

  // scanner's own decode: {col,row} -> hex key
  function automatic logic [3:0] tb_decode(input logic [3:0] pos);
    case (pos)
      4'h0: return 4'h1;  4'h1: return 4'h4;  4'h2: return 4'h7;  4'h3: return 4'h0;
      4'h4: return 4'h2;  4'h5: return 4'h5;  4'h6: return 4'h8;  4'h7: return 4'hF;
      4'h8: return 4'h3;  4'h9: return 4'h6;  4'hA: return 4'h9;  4'hB: return 4'hE;
      4'hC: return 4'hA;  4'hD: return 4'hB;  4'hE: return 4'hC;  default: return 4'hD;
    endcase
  endfunction

  function automatic logic [1:0] low_row(input logic [3:0] r);
    if (!r[0]) return 2'd0;
    if (!r[1]) return 2'd1;
    if (!r[2]) return 2'd2;
    return 2'd3;
  endfunction

  // scanner: one column per clock, rows sampled on the falling edge
  always @(posedge clk) scan_idx <= scan_idx + 2'd1;

  always @(negedge clk) begin
    if (!scan_en) begin
      seen_scan = 1'b0;
      held      = 1'b0;
    end else begin
      if (row != 4'b1111) begin
        seen_scan = 1'b1;
        seen_pos  = {scan_idx, low_row(row)};
      end
      if (scan_idx == 2'd3) begin
        if (seen_scan && !held) begin
          held = 1'b1;
          got_pos_q.push_back(seen_pos);
          got_key_q.push_back(tb_decode(seen_pos));
          number = {number[11:0], tb_decode(seen_pos)};
        end else if (!seen_scan && held) begin
          held = 1'b0;
          rel_cnt++;
          if (rel_cnt == 4) new_cycle_seen = 1'b1;
        end
        seen_scan = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // start is sampled at the next edge; returns one cycle into the first PRESS
  task automatic start_seq(input logic [15:0] c);
    code  = c;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cyc, output bit ok);
    ok  = 1'b0;
    cyc = 1;
    while (cyc <= budget) begin
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
      cyc++;
    end
  endtask

  task automatic clear_scoreboard();
    exp_key_q.delete();
    got_key_q.delete();
    exp_pos_q.delete();
    got_pos_q.delete();
    number         = 16'h0;
    rel_cnt        = 0;
    new_cycle_seen = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #23;
    n_checks++; if (row !== 4'b1111) begin n_fail++; $display("FAIL reset_row: got %b want 1111", row); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (key_active !== 1'b0) begin n_fail++; $display("FAIL reset_key_active: got %b want 0", key_active); end
    rst_n = 1'b1;
    tick();
    tick();
    man_col = 4'b1110;
    start_seq(16'h1234);
    tick();
    tick();
    n_checks++; if (row !== 4'b1110) begin n_fail++; $display("FAIL midpress_row: got %b want 1110", row); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (row !== 4'b1111) begin n_fail++; $display("FAIL async_reset_row: got %b want 1111", row); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL async_reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL async_reset_done: got %b want 0", done); end
    n_checks++; if (key_active !== 1'b0) begin n_fail++; $display("FAIL async_reset_key_active: got %b want 0", key_active); end
    #2;
    rst_n   = 1'b1;
    man_col = 4'b1111;
    tick();
  endtask

  task automatic test_timing_1234();
    logic [3:0] cols [7] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1111, 4'b0000, 4'b1100};
    logic [3:0] rows [7] = '{4'b1110, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1110, 4'b1110};
    int cyc;
    bit ok;
    man_col = 4'b1111;
    start_seq(16'h1234);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL first_press_busy: got %b want 1", busy); end
    n_checks++; if (key_active !== 1'b1) begin n_fail++; $display("FAIL first_press_key_active: got %b want 1", key_active); end
    for (int i = 0; i < 7; i++) begin
      man_col = cols[i];
      #1;
      n_checks++;
      if (row !== rows[i]) begin
        n_fail++;
        $display("FAIL key1_row col=%b: got %b want %b", cols[i], row, rows[i]);
      end
    end
    man_col = 4'b1111;
    wait_done(120, cyc, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL done_timeout: no done within 120 cycles"); end
    n_checks++; if (cyc != 65) begin n_fail++; $display("FAIL done_cycle: got N+%0d want N+65", cyc); end
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_after_done: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_width: got %b want 0", done); end
  endtask

  task automatic test_closed_loop_feda();
    int cyc;
    bit ok;
    logic [3:0] e, g;
    clear_scoreboard();
    exp_key_q.push_back(4'hF);
    exp_key_q.push_back(4'hE);
    exp_key_q.push_back(4'hD);
    exp_key_q.push_back(4'hA);
    scan_en = 1'b1;
    start_seq(16'hFEDA);
    wait_done(200, cyc, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL feda_done_timeout: no done within 200 cycles"); end
    tick();
    tick();
    scan_en = 1'b0;
    n_checks++; if (got_key_q.size() != 4) begin n_fail++; $display("FAIL feda_key_count: got %0d want 4", got_key_q.size()); end
    while (exp_key_q.size() > 0) begin
      e = exp_key_q.pop_front();
      n_checks++;
      if (got_key_q.size() == 0) begin
        n_fail++; $display("FAIL feda_key: got none want %h", e);
      end else begin
        g = got_key_q.pop_front();
        if (g !== e) begin n_fail++; $display("FAIL feda_key: got %h want %h", g, e); end
      end
    end
    n_checks++; if (number !== 16'hFEDA) begin n_fail++; $display("FAIL feda_number: got %h want feda", number); end
    n_checks++; if (new_cycle_seen !== 1'b1) begin n_fail++; $display("FAIL feda_new_cycle: got %b want 1", new_cycle_seen); end
  endtask

  task automatic test_positions_0a5c();
    int cyc;
    bit ok;
    logic [3:0] e, g;
    clear_scoreboard();
    exp_pos_q.push_back(4'h3);   // 0 at (0,3)
    exp_pos_q.push_back(4'hC);   // A at (3,0)
    exp_pos_q.push_back(4'h5);   // 5 at (1,1)
    exp_pos_q.push_back(4'hE);   // C at (3,2)
    scan_en = 1'b1;
    start_seq(16'h0A5C);
    wait_done(200, cyc, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL 0a5c_done_timeout: no done within 200 cycles"); end
    tick();
    scan_en = 1'b0;
    while (exp_pos_q.size() > 0) begin
      e = exp_pos_q.pop_front();
      n_checks++;
      if (got_pos_q.size() == 0) begin
        n_fail++; $display("FAIL 0a5c_pos: got none want (%0d,%0d)", e[3:2], e[1:0]);
      end else begin
        g = got_pos_q.pop_front();
        if (g !== e) begin
          n_fail++; $display("FAIL 0a5c_pos: got (%0d,%0d) want (%0d,%0d)", g[3:2], g[1:0], e[3:2], e[1:0]);
        end
      end
    end
    n_checks++; if (got_pos_q.size() != 0) begin n_fail++; $display("FAIL 0a5c_extra_keys: got %0d extra want 0", got_pos_q.size()); end
  endtask

  task automatic test_start_ignored();
    int n_done;
    logic [3:0] e, g;
    clear_scoreboard();
    exp_key_q.push_back(4'h1);
    exp_key_q.push_back(4'h2);
    exp_key_q.push_back(4'h3);
    exp_key_q.push_back(4'h4);
    scan_en = 1'b1;
    start_seq(16'h1234);
    repeat (34) tick();
    code  = 16'h9999;
    start = 1'b1;
    tick();
    start  = 1'b0;
    n_done = 0;
    for (int i = 0; i < 90; i++) begin
      if (done === 1'b1) n_done++;
      tick();
    end
    scan_en = 1'b0;
    n_checks++; if (n_done != 1) begin n_fail++; $display("FAIL restart_done_count: got %0d want 1", n_done); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL restart_busy_end: got %b want 0", busy); end
    n_checks++; if (got_key_q.size() != 4) begin n_fail++; $display("FAIL restart_key_count: got %0d want 4", got_key_q.size()); end
    while (exp_key_q.size() > 0) begin
      e = exp_key_q.pop_front();
      n_checks++;
      if (got_key_q.size() == 0) begin
        n_fail++; $display("FAIL restart_key: got none want %h", e);
      end else begin
        g = got_key_q.pop_front();
        if (g !== e) begin n_fail++; $display("FAIL restart_key: got %h want %h", g, e); end
      end
    end
  endtask

  task automatic test_abort();
    int n_done, n_busy, cyc;
    bit ok;
    logic [3:0] e, g;
    scan_en = 1'b0;
    man_col = 4'b1101;
    start_seq(16'h1234);
    repeat (18) tick();
    n_checks++; if (key_active !== 1'b1) begin n_fail++; $display("FAIL abort_pre_key_active: got %b want 1", key_active); end
    n_checks++; if (row !== 4'b1110) begin n_fail++; $display("FAIL abort_pre_row: got %b want 1110", row); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++; if (row !== 4'b1111) begin n_fail++; $display("FAIL abort_row: got %b want 1111", row); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
    n_checks++; if (key_active !== 1'b0) begin n_fail++; $display("FAIL abort_key_active: got %b want 0", key_active); end
    n_done = 0;
    n_busy = 0;
    for (int i = 0; i < 70; i++) begin
      if (done === 1'b1) n_done++;
      if (busy === 1'b1) n_busy++;
      tick();
    end
    n_checks++; if (n_done != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses want 0", n_done); end
    n_checks++; if (n_busy != 0) begin n_fail++; $display("FAIL abort_stays_idle: got %0d busy cycles want 0", n_busy); end

    // abort on the last PRESS cycle beats the move to RELEASE
    start_seq(16'h1234);
    repeat (7) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_priority_busy: got %b want 0", busy); end

    // start and abort together in IDLE: start wins
    code  = 16'h1234;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    n_checks++; if (key_active !== 1'b1) begin n_fail++; $display("FAIL idle_start_wins: got key_active %b want 1", key_active); end
    abort = 1'b1;
    tick();
    abort   = 1'b0;
    man_col = 4'b1111;

    // fresh sequence after abort starts from digit 0
    clear_scoreboard();
    exp_key_q.push_back(4'h7);
    exp_key_q.push_back(4'hB);
    exp_key_q.push_back(4'h0);
    exp_key_q.push_back(4'hE);
    scan_en = 1'b1;
    start_seq(16'h7B0E);
    wait_done(200, cyc, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL post_abort_done_timeout: no done within 200 cycles"); end
    n_checks++; if (cyc != 65) begin n_fail++; $display("FAIL post_abort_done_cycle: got N+%0d want N+65", cyc); end
    tick();
    scan_en = 1'b0;
    while (exp_key_q.size() > 0) begin
      e = exp_key_q.pop_front();
      n_checks++;
      if (got_key_q.size() == 0) begin
        n_fail++; $display("FAIL post_abort_key: got none want %h", e);
      end else begin
        g = got_key_q.pop_front();
        if (g !== e) begin n_fail++; $display("FAIL post_abort_key: got %h want %h", g, e); end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    code  = 16'h0;
    test_reset();
    test_timing_1234();
    test_closed_loop_feda();
    test_positions_0a5c();
    test_start_ignored();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
